// File: rtl/mv_avg_pkg.sv
// mv_avg_pkg: shared sizing helpers for the multi-channel moving averager.
//   clog2_int   - ceiling log2 of a positive integer (elaboration time)
//   k_width     - width of the log2_avg_len input for a given max log2 window
//   total_width - signed running-total width that holds MAX_LEN full-scale samples
//   clamp_k     - saturate a requested log2 window length to the maximum
package mv_avg_pkg;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // At least one bit so the port never collapses to zero width.
  function automatic int k_width(input int log2_max);
    int w;
    w = clog2_int(log2_max + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Summing 2^log2_max samples of dw bits needs log2_max guard bits.
  function automatic int total_width(input int dw, input int log2_max);
    return dw + log2_max;
  endfunction

  function automatic int clamp_k(input int k, input int log2_max);
    return (k > log2_max) ? log2_max : k;
  endfunction

endpackage

// File: rtl/mv_avg_ring_buf.sv
// mv_avg_ring_buf: delay line for the moving averager.
//   Register array DEPTH x WIDTH, one synchronous write port and one
//   asynchronous read port. Contents are deliberately not reset: the
//   averager's fill counter guarantees unwritten entries are never used.
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address (combinational)
//   rd_data  - read data, reflects contents before this cycle's write
module mv_avg_ring_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write falls out naturally: the write lands at the edge,
  // the read is combinational from the pre-edge contents.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mv_avg_mc.sv
// mv_avg_mc: multi-channel moving-average filter, window length 2^k.
//   NUM_CH lanes share one valid strobe and one ring buffer row per sample.
// Ports:
//   clk            - rising-edge clock
//   rst            - asynchronous, active-high reset
//   log2_avg_len   - requested k; clamped to LOG2_MAX_AVG_LEN; a change clears
//   flush          - synchronous clear of window contents and totals
//   data_in        - packed signed samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid  - sample strobe
//   data_out       - packed signed averages (total >>> k), held between pulses
//   data_out_valid - one-cycle pulse, one cycle after each accepted sample
//   window_full    - high once 2^k samples have been accepted since the last clear
//
// Handshake: valid-only streaming. data_in is consumed on every cycle
// data_in_valid is high (there is no ready; the block always accepts), and
// data_out_valid pulses exactly once per consumed sample, one cycle later.
module mv_avg_mc
  import mv_avg_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int LOG2_MAX_AVG_LEN = 5,
  parameter int NUM_CH           = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [k_width(LOG2_MAX_AVG_LEN)-1:0]    log2_avg_len,
  input  logic                                    flush,
  input  logic [NUM_CH*DATA_WIDTH-1:0]            data_in,
  input  logic                                    data_in_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]            data_out,
  output logic                                    data_out_valid,
  output logic                                    window_full
);

  localparam int KW      = k_width(LOG2_MAX_AVG_LEN);
  localparam int TW      = total_width(DATA_WIDTH, LOG2_MAX_AVG_LEN);
  localparam int PW      = (LOG2_MAX_AVG_LEN > 0) ? LOG2_MAX_AVG_LEN : 1;
  localparam int FW      = LOG2_MAX_AVG_LEN + 1;
  localparam int MAX_LEN = 1 << LOG2_MAX_AVG_LEN;
  localparam int XW      = NUM_CH * DATA_WIDTH;
  localparam int DW      = DATA_WIDTH;

  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_clamped;
  logic [KW-1:0] k_eff;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] len_cur;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] rd_addr;
  logic [XW-1:0] rd_data;
  logic          clear;
  logic          at_len;

  assign k_clamped = KW'(clamp_k(32'(log2_avg_len), LOG2_MAX_AVG_LEN));
  assign clear     = flush || (k_clamped != k_reg);
  assign len_cur   = FW'(1) << k_reg;
  assign at_len    = (fill_q == len_cur);

  // A sample arriving with a clear belongs to the new window, so it is
  // scaled by the new k and written at the start of the ring.
  assign k_eff   = clear ? k_clamped : k_reg;
  assign wr_addr = clear ? '0 : wr_ptr;

  // The sample leaving the window sits L entries behind the write pointer.
  // With L == MAX_LEN the low PW bits of L are zero and the read address
  // equals the write address; the async read returns the old contents.
  assign rd_addr = wr_ptr - len_cur[PW-1:0];

  mv_avg_ring_buf #(
    .WIDTH (XW),
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_ring (
    .clk     (clk),
    .wr_en   (data_in_valid),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Window bookkeeping shared by all lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg          <= '0;
      fill_q         <= '0;
      wr_ptr         <= '0;
      window_full    <= 1'b0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_in_valid;
      if (clear) begin
        k_reg       <= k_clamped;
        fill_q      <= data_in_valid ? FW'(1) : '0;
        wr_ptr      <= data_in_valid ? PW'(1) : '0;
        // Only a one-sample window is complete after its first sample.
        window_full <= data_in_valid && (k_clamped == '0);
      end else if (data_in_valid) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (!at_len) fill_q <= fill_q + FW'(1);
        window_full <= at_len || ((fill_q + FW'(1)) == len_cur);
      end
    end
  end

  // Per-channel running total and scaled output register.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic signed [TW-1:0] in_ext;
    logic signed [TW-1:0] old_ext;
    logic signed [TW-1:0] total_q;
    logic signed [TW-1:0] total_d;
    logic        [DW-1:0] out_q;

    assign in_ext  = {{(TW-DW){data_in[c*DW+DW-1]}}, data_in[c*DW +: DW]};
    assign old_ext = {{(TW-DW){rd_data[c*DW+DW-1]}}, rd_data[c*DW +: DW]};

    // The departing sample is subtracted only once the window is full,
    // so stale ring entries never reach the total.
    always_comb begin
      total_d = '0;
      if (clear) begin
        total_d = data_in_valid ? in_ext : '0;
      end else begin
        total_d = total_q + in_ext - (at_len ? old_ext : '0);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        total_q <= '0;
        out_q   <= '0;
      end else begin
        if (clear || data_in_valid) total_q <= total_d;
        // |total| <= L * 2^(DW-1), so the shifted value always fits DW bits.
        if (data_in_valid) out_q <= DW'(total_d >>> k_eff);
      end
    end

    assign data_out[c*DW +: DW] = out_q;
  end

endmodule

// File: tb/tb_mv_avg_mc.sv
// tb_mv_avg_mc: directed bench for mv_avg_mc with a window-of-samples model.
module tb_mv_avg_mc;

  localparam int DW   = 16;
  localparam int L2M  = 5;
  localparam int NCH  = 2;
  localparam int KW   = 3;
  localparam int XW   = NCH * DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KW-1:0] log2_avg_len = 3'd2;
  logic          flush = 1'b0;
  logic [XW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic [XW-1:0] data_out;
  logic          data_out_valid;
  logic          window_full;

  always #5 clk = ~clk;

  mv_avg_mc #(
    .DATA_WIDTH       (DW),
    .LOG2_MAX_AVG_LEN (L2M),
    .NUM_CH           (NCH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .log2_avg_len   (log2_avg_len),
    .flush          (flush),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .window_full    (window_full)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] dout_ch(input int c);
    logic [DW-1:0] v;
    v = data_out[c*DW +: DW];
    return $signed(v);
  endfunction

  // ---------------- behavioural model ----------------
  // Keeps the samples of the current window since the last clear and
  // averages them as sum / 2^k (floor), which is what the outputs must show.
  logic [XW-1:0] exp_q[$];
  int            k_m = 0;
  logic [XW-1:0] exp_out = '0;
  logic          exp_valid = 1'b0;
  logic          exp_full = 1'b0;

  always @(posedge clk) begin
    int            kc;
    longint        s;
    logic [XW-1:0] e;
    logic [DW-1:0] smp;
    if (rst) begin
      exp_q.delete();
      k_m       = 0;
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_full  = 1'b0;
    end else begin
      kc = (int'(log2_avg_len) > L2M) ? L2M : int'(log2_avg_len);
      if (flush || kc != k_m) begin
        exp_q.delete();
        k_m      = kc;
        exp_full = 1'b0;
      end
      exp_valid = data_in_valid;
      if (data_in_valid) begin
        exp_q.push_back(data_in);
        if (exp_q.size() > (1 << k_m)) void'(exp_q.pop_front());
        for (int c = 0; c < NCH; c++) begin
          s = 0;
          for (int i = 0; i < exp_q.size(); i++) begin
            e   = exp_q[i];
            smp = e[c*DW +: DW];
            s   = s + longint'($signed(smp));
          end
          exp_out[c*DW +: DW] = DW'(s >>> k_m);
        end
        exp_full = (exp_q.size() == (1 << k_m));
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [DW-1:0] ev;
    #3;
    check("out_valid", 64'(data_out_valid), 64'(exp_valid));
    check("window_full", 64'(window_full), 64'(exp_full));
    for (int c = 0; c < NCH; c++) begin
      ev = exp_out[c*DW +: DW];
      check($sformatf("data_out_ch%0d", c), dout_ch(c), $signed(ev));
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int k, input bit f, input bit v, input int c0, input int c1);
    @(negedge clk);
    log2_avg_len  = KW'(k);
    flush         = f;
    data_in_valid = v;
    data_in       = {DW'(c1), DW'(c0)};
    @(posedge clk);
    #4;
  endtask

  // ---------------- directed stimulus ----------------
  int gap_in  [3] = '{10, 20, 30};
  int gap_exp [3] = '{5, 15, 25};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #4;
    check("rst_dout0", dout_ch(0), 0);
    check("rst_dout1", dout_ch(1), 0);
    check("rst_valid", 64'(data_out_valid), 0);
    check("rst_full", 64'(window_full), 0);
    rst = 1'b0;

    // Ramp-up, k=2 (release with k=2 clears on the first cycle)
    send(2, 0, 1, 100, -100);
    check("ramp1_ch0", dout_ch(0), 25);
    check("ramp1_ch1", dout_ch(1), -25);
    send(2, 0, 1, 100, -100);
    check("ramp2_ch0", dout_ch(0), 50);
    send(2, 0, 1, 100, -100);
    check("ramp3_ch0", dout_ch(0), 75);
    check("ramp3_full", 64'(window_full), 0);
    send(2, 0, 1, 100, -100);
    check("ramp4_ch0", dout_ch(0), 100);
    check("ramp4_ch1", dout_ch(1), -100);
    check("ramp4_full", 64'(window_full), 1);

    // Step response
    send(2, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(2, 0, 1, 0, 0);
    check("step_zero", dout_ch(0), 0);
    send(2, 0, 1, 40, -40);
    check("step_up1", dout_ch(0), 10);
    send(2, 0, 1, 40, -40);
    check("step_up2", dout_ch(0), 20);
    send(2, 0, 1, 40, -40);
    check("step_up3", dout_ch(0), 30);
    send(2, 0, 1, 40, -40);
    check("step_up4", dout_ch(0), 40);
    check("step_up4_ch1", dout_ch(1), -40);
    send(2, 0, 1, 40, -40);
    send(2, 0, 1, 40, -40);
    check("step_hold", dout_ch(0), 40);
    send(2, 0, 1, -40, 40);
    check("step_dn1", dout_ch(0), 20);
    send(2, 0, 1, -40, 40);
    check("step_dn2", dout_ch(0), 0);
    send(2, 0, 1, -40, 40);
    check("step_dn3", dout_ch(0), -20);
    send(2, 0, 1, -40, 40);
    check("step_dn4", dout_ch(0), -40);

    // Extremes, k=5 (first half requested as 7, which clamps to 5)
    for (int i = 0; i < 16; i++) send(7, 0, 1, 32767, -32768);
    for (int i = 0; i < 16; i++) send(5, 0, 1, 32767, -32768);
    check("ext_max_ch0", dout_ch(0), 32767);
    check("ext_max_ch1", dout_ch(1), -32768);
    check("ext_max_full", 64'(window_full), 1);
    for (int i = 0; i < 16; i++) send(5, 0, 1, -32768, 32767);
    check("ext_mid_ch0", dout_ch(0), -1);
    for (int i = 0; i < 16; i++) send(5, 0, 1, -32768, 32767);
    check("ext_min_ch0", dout_ch(0), -32768);
    check("ext_min_ch1", dout_ch(1), 32767);

    // Gapped valid, k=1
    send(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      send(1, 0, 1, gap_in[i], -gap_in[i]);
      check("gap_out", dout_ch(0), gap_exp[i]);
      check("gap_valid", 64'(data_out_valid), 1);
      send(1, 0, 0, 999, 999);
      check("gap_idle_valid", 64'(data_out_valid), 0);
      check("gap_hold", dout_ch(0), gap_exp[i]);
      send(1, 0, 0, 999, 999);
    end

    // Window change k=2 -> 3 with a sample in the same cycle, then flush
    send(2, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(2, 0, 1, 8, 8);
    check("wc_pre", dout_ch(0), 8);
    check("wc_pre_full", 64'(window_full), 1);
    send(3, 0, 1, 16, 16);
    check("wc_first", dout_ch(0), 2);
    check("wc_first_full", 64'(window_full), 0);
    for (int i = 0; i < 6; i++) send(3, 0, 1, 16, 16);
    check("wc_7_full", 64'(window_full), 0);
    check("wc_7_out", dout_ch(0), 14);
    send(3, 0, 1, 16, 16);
    check("wc_8_out", dout_ch(0), 16);
    check("wc_8_full", 64'(window_full), 1);
    send(3, 1, 1, 8, 8);
    check("flush_first", dout_ch(0), 1);
    check("flush_full", 64'(window_full), 0);

    // Async reset mid-stream, then passthrough at k=0
    for (int i = 0; i < 4; i++) send(3, 0, 1, 50, -50);
    @(negedge clk);
    data_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout0", dout_ch(0), 0);
    check("arst_dout1", dout_ch(1), 0);
    check("arst_full", 64'(window_full), 0);
    check("arst_valid", 64'(data_out_valid), 0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    send(0, 0, 1, 123, -7);
    check("pass1_ch0", dout_ch(0), 123);
    check("pass1_ch1", dout_ch(1), -7);
    check("pass1_full", 64'(window_full), 1);
    send(0, 0, 1, 5, 6);
    check("pass2_ch0", dout_ch(0), 5);
    check("pass2_ch1", dout_ch(1), 6);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mv_avg_mc.md
# mv_avg_mc

Multi-channel moving-average filter with runtime-selectable window length 2^k, k ≤ LOG2_MAX_AVG_LEN. NUM_CH lanes share one valid strobe. It replaces the FIFO-based single-channel averager in xpu: the delay line is an internal ring buffer, the window length can change on the fly, and a window-full flag is reported. Typical uses are I/Q or per-antenna RSSI/power smoothing ahead of CCA and threshold logic.

## Interface
- DATA_WIDTH, 16, per-channel sample width, signed two's complement
- LOG2_MAX_AVG_LEN, 5, log2 of the maximum window and of the ring depth (MAX_LEN = 1<<LOG2_MAX_AVG_LEN)
- NUM_CH, 2, number of parallel channels
- clk  in  1  sole clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- log2_avg_len  in  ceil(log2(LOG2_MAX_AVG_LEN+1))  runtime window selection k; values above LOG2_MAX_AVG_LEN clamp to LOG2_MAX_AVG_LEN
- flush  in  1  synchronous clear of the window contents and totals
- data_in  in  NUM_CH*DATA_WIDTH  packed samples; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- data_in_valid  in  1  sample strobe; may be asserted every cycle
- data_out  out  NUM_CH*DATA_WIDTH  packed averages, signed
- data_out_valid  out  1  one-cycle pulse per accepted input
- window_full  out  1  high once L = 2^k samples have been accepted since the last clear

## Operation
- The effective k is the clamped log2_avg_len, registered as k_reg. L = 1<<k_reg.
- Per-channel running total width is TW = DATA_WIDTH + LOG2_MAX_AVG_LEN, signed.
- On an accepted sample (data_in_valid):
  - The ring buffer is written at wr_ptr. wr_ptr wraps modulo MAX_LEN.
  - The old sample is read at (wr_ptr − L) mod MAX_LEN, read-before-write. With L = MAX_LEN this is the same address.
  - total_c ← total_c + sext(in_c) − (fill == L ? sext(old_c) : 0).
  - fill counter increments and saturates at L.
- data_out_c = total_c >>> k_reg (arithmetic shift), low DATA_WIDTH bits. This cannot overflow.
- Before the window is full, the output is the partial sum divided by the full L (ramp-up behaviour).
- Clear event: flush = 1, or clamped log2_avg_len ≠ k_reg.
  - Totals, fill and wr_ptr go to 0, window_full goes to 0, and k_reg loads the new value.
  - A data_in_valid in the same cycle is taken as the first sample of the new window: total = sext(in), fill = 1.
- k = 0 gives passthrough: data_out = data_in, and window_full is set after the first sample.
- Ring-buffer contents are never reset. Fill gating guarantees stale entries are never subtracted.
- Cycles without data_in_valid leave all state unchanged.

## Timing
- Latency is 1 cycle: data_in_valid at cycle n gives data_out_valid at n+1, with data_out covering samples up to and including n.
- Throughput is one sample per cycle, sustained.
- data_out holds its value between valid pulses.
- window_full rises in the same cycle as the data_out_valid of the L-th sample.
- window_full falls in the cycle after a clear event.
- Reset values are all 0: data_out, data_out_valid, window_full, totals, wr_ptr, fill, k_reg.
  - k_reg = 0 after reset, so a non-zero log2_avg_len present at release triggers a clear on the first cycle.
- Asserting rst mid-stream zeroes the outputs immediately (asynchronous). In-flight samples are lost.

## Structure
- Shared package mv_avg_pkg holds:
  - a function for TW;
  - a clog2 helper for the log2_avg_len width;
  - the clamp function.
- Sub-module mv_avg_ring_buf:
  - NUM_CH*DATA_WIDTH wide, MAX_LEN deep;
  - single write port plus one asynchronous read port at a computed address;
  - register array, no reset;
  - wr_ptr is owned by the top.
- The top holds k_reg, the fill counter, a generate loop of NUM_CH total/shift lanes, and the output registers.

## Test plan
Defaults DATA_WIDTH=16, LOG2_MAX_AVG_LEN=5, NUM_CH=2.
- **Ramp-up:** k=2, ch0=100, ch1=−100, four back-to-back valids → ch0 outputs 25, 50, 75, 100; ch1 outputs −25, −50, −75, −100; window_full rises with the 4th output.
- **Step response:** k=2, four zeros then continuous 40 → 10, 20, 30, 40, 40, … Then a step to −40 → 20, 0, −20, −40.
- **Extremes:**
  - k=5, 32 × 32767 → final output 32767;
  - then 32 × −32768 → final output −32768, no wrap.
  - k=5 exercises the read-address = write-address case.
- **Gapped valid:** k=1, valids every 3rd cycle with 10, 20, 30 → outputs 5, 15, 25, each one cycle after its valid; data_out_valid low otherwise.
- **Window change:** at k=2, after 6 samples of 8, change log2_avg_len to 3 while driving sample 16 in the same cycle → next output 2 (16>>>3); window_full low until 8 new samples. flush behaves identically.
- **Async reset and passthrough:**
  - rst pulsed mid-stream → data_out and window_full are 0 without waiting for a clock edge;
  - after release with k=0, input 123 → output 123 one cycle later, window_full = 1.
